// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the pipeline WB stage and a
//   multi-cycle unit (MDU). The pipeline normally wins; the MDU takes the port
//   whenever the pipeline is not writing. If the MDU loses STARVE_LIMIT
//   consecutive cycles, the pipeline is frozen for one cycle (stall_req) and
//   the MDU result is written.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   wb_regwrite/rd/data : pipeline WB-stage write request
//   mdu_valid/rd/data   : MDU result request (held stable until mdu_ready)
//   mdu_ready           : MDU result accepted this cycle (combinational)
//   stall_req           : pipeline freeze request (high while in FORCE)
//   rf_we/waddr/wdata   : registered register-file write port
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_regwrite,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        stall_req,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  starve_cnt_q, starve_cnt_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_waddr_q, rf_waddr_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;

   logic        pipe_req;
   logic        in_force;
   logic        grant_mdu;
   logic [2:0]  cnt_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   always_comb begin
      pipe_req  = wb_regwrite & (wb_rd != 5'd0);
      in_force  = (state_q == FORCE);
      grant_mdu = mdu_valid & (in_force | ~pipe_req);
      cnt_inc   = (starve_cnt_q == 3'd7) ? 3'd7 : starve_cnt_q + 3'd1;

      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      rf_we_d      = 1'b0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;

      if (grant_mdu) begin
         state_d      = IDLE;
         starve_cnt_d = '0;
         // rd=0 results are consumed but never written
         if (mdu_rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mdu_rd;
            rf_wdata_d = mdu_data;
         end
      end else if (in_force) begin
         // MDU withdrew during the forced cycle; FORCE still lasts one cycle
         state_d      = IDLE;
         starve_cnt_d = '0;
      end else begin
         if (pipe_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
         end
         if (mdu_valid) begin
            // MDU lost arbitration to the pipeline this cycle
            starve_cnt_d = cnt_inc;
            state_d      = (cnt_inc == 3'(STARVE_LIMIT)) ? FORCE : WAIT;
         end else if (state_q == WAIT) begin
            state_d      = IDLE;
            starve_cnt_d = '0;
         end
      end

      // reset gating keeps the handshake quiet while rst is held
      mdu_ready = ~rst & grant_mdu;
      stall_req = in_force;
      rf_we     = rf_we_q;
      rf_waddr  = rf_waddr_q;
      rf_wdata  = rf_wdata_q;
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        stall_req;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int unsigned errors = 0;
   int unsigned checks = 0;

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_regwrite (wb_regwrite),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .mdu_valid   (mdu_valid),
      .mdu_rd      (mdu_rd),
      .mdu_data    (mdu_data),
      .mdu_ready   (mdu_ready),
      .stall_req   (stall_req),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; land 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
      wb_regwrite = we;
      wb_rd       = rd;
      wb_data     = d;
   endtask

   task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mdu_valid = v;
      mdu_rd    = rd;
      mdu_data  = d;
   endtask

   initial begin
      rst = 1'b1;
      pipe(1'b0, 5'd0, 32'h0);
      mdu(1'b1, 5'd3, 32'h33);
      #2;
      // reset state, before any clock edge
      chk("rst_rf_we",     {31'd0, rf_we},     32'd0);
      chk("rst_rf_waddr",  {27'd0, rf_waddr},  32'd0);
      chk("rst_rf_wdata",  rf_wdata,           32'd0);
      chk("rst_stall",     {31'd0, stall_req}, 32'd0);
      chk("rst_mdu_ready", {31'd0, mdu_ready}, 32'd0);
      step();
      step();
      mdu(1'b0, 5'd0, 32'h0);
      rst = 1'b0;
      step();
      chk("idle_rf_we", {31'd0, rf_we}, 32'd0);

      // plain pipeline write
      pipe(1'b1, 5'd5, 32'hDEADBEEF);
      step();
      pipe(1'b0, 5'd0, 32'h0);
      chk("pipe_we",    {31'd0, rf_we},    32'd1);
      chk("pipe_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("pipe_wdata", rf_wdata,          32'hDEADBEEF);
      step();
      chk("hold_we",    {31'd0, rf_we},    32'd0);
      chk("hold_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("hold_wdata", rf_wdata,          32'hDEADBEEF);

      // MDU alone: accepted in the same cycle
      mdu(1'b1, 5'd9, 32'h12345678);
      #1;
      chk("mdu_ready_same", {31'd0, mdu_ready}, 32'd1);
      step();
      mdu(1'b0, 5'd0, 32'h0);
      chk("mdu_we",    {31'd0, rf_we},    32'd1);
      chk("mdu_waddr", {27'd0, rf_waddr}, 32'd9);
      chk("mdu_wdata", rf_wdata,          32'h12345678);
      chk("mdu_cnt",   {29'd0, dut.starve_cnt_q}, 32'd0);
      chk("mdu_stall", {31'd0, stall_req}, 32'd0);

      // starvation: 4 lost cycles, one forced cycle, then the held pipe write
      mdu(1'b1, 5'd7, 32'hAAAA0007);
      for (int i = 1; i <= 4; i++) begin
         pipe(1'b1, 5'(i), 32'h100 + i);
         #1;
         chk("starve_ready", {31'd0, mdu_ready}, 32'd0);
         chk("starve_stall", {31'd0, stall_req}, 32'd0);
         step();
         chk("starve_waddr", {27'd0, rf_waddr}, i);
         chk("starve_wdata", rf_wdata,          32'h100 + i);
      end
      chk("force_cnt",   {29'd0, dut.starve_cnt_q}, 32'd4);
      pipe(1'b1, 5'd5, 32'h105);
      #1;
      chk("force_stall", {31'd0, stall_req}, 32'd1);
      chk("force_ready", {31'd0, mdu_ready}, 32'd1);
      step();
      mdu(1'b0, 5'd0, 32'h0);
      chk("force_we",    {31'd0, rf_we},    32'd1);
      chk("force_waddr", {27'd0, rf_waddr}, 32'd7);
      chk("force_wdata", rf_wdata,          32'hAAAA0007);
      chk("force_once",  {31'd0, stall_req}, 32'd0);
      step();
      pipe(1'b0, 5'd0, 32'h0);
      chk("held_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("held_wdata", rf_wdata,          32'h105);

      // withdrawn MDU request clears the starvation count
      mdu(1'b1, 5'd8, 32'h88);
      pipe(1'b1, 5'd2, 32'h22);
      step();
      step();
      chk("wait_cnt2", {29'd0, dut.starve_cnt_q}, 32'd2);
      mdu(1'b0, 5'd0, 32'h0);
      step();
      chk("withdraw_cnt", {29'd0, dut.starve_cnt_q}, 32'd0);
      pipe(1'b0, 5'd0, 32'h0);
      step();

      // pipeline write to x0 is not a request: MDU wins immediately
      pipe(1'b1, 5'd0, 32'hFFFF0000);
      mdu(1'b1, 5'd10, 32'hCAFE0010);
      #1;
      chk("x0_ready", {31'd0, mdu_ready}, 32'd1);
      step();
      mdu(1'b0, 5'd0, 32'h0);
      pipe(1'b0, 5'd0, 32'h0);
      chk("x0_waddr", {27'd0, rf_waddr}, 32'd10);
      chk("x0_wdata", rf_wdata,          32'hCAFE0010);
      chk("x0_cnt",   {29'd0, dut.starve_cnt_q}, 32'd0);

      // MDU result to rd=0: accepted, no write, outputs held
      mdu(1'b1, 5'd0, 32'h55555555);
      #1;
      chk("rd0_ready", {31'd0, mdu_ready}, 32'd1);
      step();
      mdu(1'b0, 5'd0, 32'h0);
      chk("rd0_we",    {31'd0, rf_we},    32'd0);
      chk("rd0_waddr", {27'd0, rf_waddr}, 32'd10);
      chk("rd0_wdata", rf_wdata,          32'hCAFE0010);

      // reset pulsed mid-FORCE
      mdu(1'b1, 5'd12, 32'hBBBB000C);
      pipe(1'b1, 5'd3, 32'h333);
      for (int i = 0; i < 4; i++) step();
      chk("rforce_stall", {31'd0, stall_req}, 32'd1);
      chk("rforce_ready", {31'd0, mdu_ready}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rmid_stall", {31'd0, stall_req}, 32'd0);
      chk("rmid_ready", {31'd0, mdu_ready}, 32'd0);
      chk("rmid_we",    {31'd0, rf_we},     32'd0);
      chk("rmid_waddr", {27'd0, rf_waddr},  32'd0);
      chk("rmid_wdata", rf_wdata,           32'd0);
      mdu(1'b0, 5'd0, 32'h0);
      pipe(1'b0, 5'd0, 32'h0);
      step();
      rst = 1'b0;
      step();
      chk("rpost_we",    {31'd0, rf_we},     32'd0);
      chk("rpost_stall", {31'd0, stall_req}, 32'd0);
      step();
      chk("rpost_we2",   {31'd0, rf_we},     32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
